alu_issue: RTL and testbench
============================

# alu_issue

Issue stage that drives the ALU. It accepts RV32 ALU instructions over a valid/ready handshake and reads source operands from the register file. It decodes each instruction into the ALU's 4-bit operation code and two 32-bit operands, then presents them from a single output register with backpressure and flush support. It sits between fetch/decode and the ALU/writeback path.

## Interface
- `XLEN`, 32: operand width. Fixed at 32 for RV32.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard the held and the incoming instruction.
- `in_valid` in 1: `in_instr` is valid.
- `in_ready` out 1: stage can accept this cycle.
- `in_instr` in 32: raw instruction word.
- `rs1_addr` out 5: combinational, `in_instr[19:15]`.
- `rs2_addr` out 5: combinational, `in_instr[24:20]`.
- `rs1_data` in 32: same-cycle register file read data.
- `rs2_data` in 32: same-cycle register file read data.
- `out_valid` out 1: ALU bundle is valid.
- `out_ready` in 1: ALU/writeback accepts the bundle.
- `opcode` out 4: ALU operation code.
- `num1` out 32: first ALU operand.
- `num2` out 32: second ALU operand.
- `rd` out 5: destination register.
- `wen` out 1: write enable. 0 for illegal instructions or when rd = 0.
- `illegal` out 1: instruction not supported by the ALU.

## Operation
- Supported ALU operation codes:
  - 0 add
  - 1 sub
  - 2 and
  - 3 or
  - 4 xor
  - 5 unsigned less-than
  - 6 unsigned greater-than (not produced by RV32 decode; reserved)
- R-type (major opcode 0x33, funct7 0x00 or 0x20):
  - ADD → 0, SUB → 1, AND → 2, OR → 3, XOR → 4, SLTU → 5.
  - num1 = rs1_data, num2 = rs2_data.
- I-type (major opcode 0x13):
  - ADDI → 0, ANDI → 2, ORI → 3, XORI → 4, SLTIU → 5.
  - num1 = rs1_data.
  - num2 = `in_instr[31:20]` sign-extended to 32 bits. SLTIU also uses the sign-extended immediate, compared unsigned.
- Any other encoding (SLT, SLTI, shifts, SUB with funct7 ≠ 0x20, non-ALU major opcodes):
  - illegal = 1, wen = 0, opcode = 0, num1 = num2 = 0.
  - The instruction is still issued so that trap logic sees it.
- wen = !illegal && rd ≠ 0.
- Handshake:
  - Transfer in when `in_valid && in_ready`.
  - Transfer out when `out_valid && out_ready`.
  - `in_ready = !out_valid || out_ready`, combinational, no dependency on `in_valid`.
- Output register holds all bundle fields stable while `out_valid && !out_ready`.
- Flush:
  - Next cycle `out_valid` = 0, regardless of `in_valid`/`out_ready`.
  - An input accepted in the flush cycle is dropped.
  - Flush has priority over load.
- Simultaneous out-transfer and in-transfer in the same cycle: the new bundle is loaded and `out_valid` stays 1 (full throughput).

## Timing
- Latency: 1 cycle, from input acceptance to `out_valid`.
- Throughput: 1 instruction/cycle when `out_ready` = 1.
- Register file read is same-cycle. `rs1_addr`/`rs2_addr` follow `in_instr` combinationally and `rs*_data` are sampled at the accept edge.
- Reset, applied at a clock edge:
  - `out_valid`, `opcode`, `num1`, `num2`, `rd`, `wen`, `illegal` = 0.
  - `in_ready` = 1 in the first cycle after reset.
- Reset asserted while a bundle is held and stalled: the bundle is discarded and no transfer is reported.
- Two-state control only (`empty`/`full` is the value of `out_valid`):
  - `empty` → `full` on accept.
  - `full` → `empty` on drain without accept, on flush, or on reset.
  - `full` → `full` on stall, or on drain plus accept.
- Datapath registers load only on accept. They are not cleared on flush; only valid is cleared.

## Structure
- The shared package `alu_pkg` holds:
  - `alu_op_e`, a 4-bit enum with values 0–6 matching the ALU.
  - Major opcode constants `OP_REG` = 7'h33 and `OP_IMM` = 7'h13.
  - funct3/funct7 constants.
  - The `alu_bundle_t` struct (opcode, num1, num2, rd, wen, illegal).
- One sub-module `alu_ctrl` does the purely combinational decode: instruction → `alu_op_e`, imm_sel, illegal.
- `alu_issue` owns only the handshake and the output register.

## Test plan
- Reset then ADDI x1,x2,-1: `in_instr` 0xFFF10093, `rs1_data` 5.
  - Expect `rs1_addr` 2.
  - Next cycle: `opcode` 0, `num1` 5, `num2` 0xFFFFFFFF, `rd` 1, `wen` 1, `illegal` 0.
- SUB x3,x1,x2: `in_instr` 0x402081B3, `rs1_data` 9, `rs2_data` 4.
  - Expect `opcode` 1, `num1` 9, `num2` 4, `rd` 3.
  - Same word with funct7 0x01 (0x022081B3): expect `illegal` 1, `wen` 0.
- Backpressure: hold `out_ready` 0 for 3 cycles with `in_valid` 1.
  - Expect `in_ready` 0 and the bundle fields unchanged.
  - Raise `out_ready`: the next instruction appears the cycle after, with no loss or duplication over 8 streamed instructions.
- Flush while full, with `in_valid` 1 in the same cycle: expect `out_valid` 0 next cycle and the incoming instruction never issued.
- ADDI x0,x0,0 (0x00000013): expect `wen` 0, `illegal` 0, `out_valid` 1.
- Reset asserted mid-stall: expect `out_valid` 0 and all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue stage: operation codes, RV32 opcode fields
// and the registered bundle handed to the ALU.
package alu_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluAnd = 4'd2,
        AluOr  = 4'd3,
        AluXor = 4'd4,
        AluLtu = 4'd5,
        AluGtu = 4'd6
    } alu_op_e;

    localparam logic [6:0] OP_REG = 7'h33;
    localparam logic [6:0] OP_IMM = 7'h13;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        alu_op_e             opcode;
        logic [WORD_W-1:0]   num1;
        logic [WORD_W-1:0]   num2;
        logic [4:0]          rd;
        logic                wen;
        logic                illegal;
    } alu_bundle_t;

    function automatic logic [WORD_W-1:0] sext_imm12(input logic [11:0] imm);
        return {{(WORD_W - 12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Combinational decode of an RV32 instruction into an ALU operation, operand select and an
// illegal flag. Illegal encodings always report AluAdd with the register operand selected.
module alu_ctrl
    import alu_pkg::*;
(
    input  logic [6:0] major,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_e    op,
    output logic       imm_sel,
    output logic       illegal
);

    always_comb begin
        op      = AluAdd;
        imm_sel = 1'b0;
        illegal = 1'b1;

        case (major)
            OP_REG: begin
                if (funct7 == F7_BASE) begin
                    illegal = 1'b0;
                    case (funct3)
                        F3_ADD:  op = AluAdd;
                        F3_AND:  op = AluAnd;
                        F3_OR:   op = AluOr;
                        F3_XOR:  op = AluXor;
                        F3_SLTU: op = AluLtu;
                        default: illegal = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    op      = AluSub;
                    illegal = 1'b0;
                end
            end
            OP_IMM: begin
                imm_sel = 1'b1;
                illegal = 1'b0;
                // SLTI and the shift immediates are not ALU ops here
                case (funct3)
                    F3_ADD:  op = AluAdd;
                    F3_AND:  op = AluAnd;
                    F3_OR:   op = AluOr;
                    F3_XOR:  op = AluXor;
                    F3_SLTU: op = AluLtu;
                    default: illegal = 1'b1;
                endcase
            end
            default: ;
        endcase

        if (illegal) begin
            op      = AluAdd;
            imm_sel = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: valid/ready input, same-cycle register file read, single output register
// with backpressure and flush.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = WORD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      opcode,
    output logic [XLEN-1:0] num1,
    output logic [XLEN-1:0] num2,
    output logic [4:0]      rd,
    output logic            wen,
    output logic            illegal
);

    logic        valid_q;
    alu_bundle_t bundle_q;
    alu_bundle_t bundle_d;
    alu_op_e     dec_op;
    logic        dec_imm_sel;
    logic        dec_illegal;
    logic        accept;
    logic        load;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    alu_ctrl u_ctrl (
        .major   (in_instr[6:0]),
        .funct3  (in_instr[14:12]),
        .funct7  (in_instr[31:25]),
        .op      (dec_op),
        .imm_sel (dec_imm_sel),
        .illegal (dec_illegal)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // An instruction accepted during flush is dropped, so it never touches the datapath
    assign load     = accept && !flush;

    always_comb begin
        bundle_d         = '0;
        bundle_d.rd      = in_instr[11:7];
        bundle_d.illegal = dec_illegal;
        if (!dec_illegal) begin
            bundle_d.opcode = dec_op;
            bundle_d.num1   = rs1_data;
            bundle_d.num2   = dec_imm_sel ? sext_imm12(in_instr[31:20]) : rs2_data;
            bundle_d.wen    = (in_instr[11:7] != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
            if (load) begin
                bundle_q <= bundle_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign opcode    = bundle_q.opcode;
    assign num1      = bundle_q.num1;
    assign num2      = bundle_q.num2;
    assign rd        = bundle_q.rd;
    assign wen       = bundle_q.wen;
    assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed encodings plus randomized streaming against a
// queue-based reference model of the issue stage.
module tb_alu_issue;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, rs1_data, rs2_data, num1, num2;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic [3:0]  opcode;
    logic        wen, illegal;
    logic [31:0] rf [32];
    exp_t        act;
    exp_t        q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];
    assign act      = {opcode, num1, num2, rd, wen, illegal};

    alu_issue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .num1      (num1),
        .num2      (num2),
        .rd        (rd),
        .wen       (wen),
        .illegal   (illegal)
    );

    // Reference: what the ALU should receive for an instruction, from the ISA mnemonic table.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        logic [6:0]  maj, f7;
        logic [2:0]  f3;
        logic [31:0] imm;
        int          code;
        maj  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        imm  = {{20{ins[31]}}, ins[31:20]};
        code = -1;
        if (maj == 7'h33 && f7 == 7'h00) begin
            case (f3)
                3'd0: code = 0;
                3'd7: code = 2;
                3'd6: code = 3;
                3'd4: code = 4;
                3'd3: code = 5;
                default: code = -1;
            endcase
        end else if (maj == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
            code = 1;
        end else if (maj == 7'h13) begin
            case (f3)
                3'd0: code = 0;
                3'd7: code = 2;
                3'd6: code = 3;
                3'd4: code = 4;
                3'd3: code = 5;
                default: code = -1;
            endcase
        end
        e    = '0;
        e.rd = ins[11:7];
        if (code < 0) begin
            e.ill = 1'b1;
        end else begin
            e.op  = code[3:0];
            e.n1  = rf[ins[19:15]];
            e.n2  = (maj == 7'h33) ? rf[ins[24:20]] : imm;
            e.wen = (ins[11:7] != 5'd0);
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] maj, f7;
        int         s;
        s   = $urandom_range(0, 9);
        maj = (s < 4) ? 7'h33 : ((s < 8) ? 7'h13 : 7'($urandom));
        if ($urandom_range(0, 3) == 0) f7 = 7'($urandom);
        else f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), maj};
    endfunction

    // Advance one clock and update the expected contents of the stage.
    task automatic tick();
        exp_t nb;
        bit   rdy;
        nb  = model(in_instr);
        rdy = (q.size() == 0) || out_ready;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) q.push_back(nb);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (act !== '0) begin
            errors++; $display("FAIL reset_bundle got %h want 0", act);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_directed();
        exp_t want;
        out_ready = 1'b1; in_valid = 1'b1;
        rf[2] = 32'd5; in_instr = 32'hFFF10093;
        @(negedge clk);
        checks++;
        if (rs1_addr !== 5'd2) begin
            errors++; $display("FAIL addi_rs1_addr got %0d want 2", rs1_addr);
        end
        tick();
        rf[1] = 32'd9; rf[2] = 32'd4; in_instr = 32'h402081B3;
        @(negedge clk);
        want = '{op: 4'd0, n1: 32'd5, n2: 32'hFFFFFFFF, rd: 5'd1, wen: 1'b1, ill: 1'b0};
        checks++;
        if (out_valid !== 1'b1 || act !== want) begin
            errors++; $display("FAIL addi got v=%b %h want v=1 %h", out_valid, act, want);
        end
        tick();
        in_instr = 32'h022081B3;
        @(negedge clk);
        want = '{op: 4'd1, n1: 32'd9, n2: 32'd4, rd: 5'd3, wen: 1'b1, ill: 1'b0};
        checks++;
        if (act !== want) begin
            errors++; $display("FAIL sub got %h want %h", act, want);
        end
        tick();
        in_instr = 32'h00000013;
        @(negedge clk);
        want = '{op: 4'd0, n1: 32'd0, n2: 32'd0, rd: 5'd3, wen: 1'b0, ill: 1'b1};
        checks++;
        if (act !== want) begin
            errors++; $display("FAIL bad_funct7 got %h want %h", act, want);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        want = '0;
        checks++;
        if (out_valid !== 1'b1 || act !== want) begin
            errors++; $display("FAIL addi_x0 got v=%b %h want v=1 %h", out_valid, act, want);
        end
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty got %b want 0", out_valid);
        end
    endtask

    // Per-cycle randomized traffic; every cycle compares handshake and head-of-stage contents.
    task automatic test_stream(input int cycles, input int stall_pct, input int flush_pct);
        for (int c = 0; c < cycles; c++) begin
            in_valid  = ($urandom_range(0, 99) < 80);
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            flush     = ($urandom_range(0, 99) < flush_pct);
            in_instr  = rand_instr();
            rf[$urandom_range(1, 31)] = $urandom;
            @(negedge clk);
            checks++;
            if (in_ready !== ((q.size() == 0) || out_ready)) begin
                errors++; $display("FAIL stream_in_ready c=%0d got %b", c, in_ready);
            end
            checks++;
            if (out_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL stream_out_valid c=%0d got %b want %b", c, out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if (act !== q[0]) begin
                    errors++; $display("FAIL stream_bundle c=%0d got %h want %h", c, act, q[0]);
                end
            end
            tick();
        end
        flush = 1'b0;
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h402081B3;
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_instr = rand_instr();
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_in_ready c=%0d got %b want 0", c, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || act !== q[0]) begin
                errors++; $display("FAIL stall_hold c=%0d got %h want %h", c, act, q[0]);
            end
            tick();
        end
        // Stream 8 back-to-back instructions with the sink always ready
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 8);
            in_instr = rand_instr();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || act !== q[0]) begin
                errors++; $display("FAIL b2b c=%0d got v=%b %h want %h", c, out_valid, act, q[0]);
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_extra got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'hFFF10093;
        tick();
        in_instr = 32'h402081B3; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_out_valid c=%0d got %b want 0", c, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset_stall();
        in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h402081B3;
        tick();
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || act !== '0) begin
            errors++; $display("FAIL reset_stall got v=%b %h want v=0 0", out_valid, act);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_stall_ready got %b want 1", in_ready);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_stream(300, 30, 0);
        test_stream(300, 50, 5);
        test_reset_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
